nor_sweep_checker: RTL
======================

# nor_sweep_checker

Parametrised, self-checking exhaustive sweeper for an N-input NOR gate under test. On `start` it steps a counter through all 2^WIDTH input patterns, drives each onto the gate inputs, waits a programmable settle time, and compares the gate output against a golden NOR. It tallies mismatches and reports pass/fail. It replaces hand-written fixed-vector NOR benches and sits beside the gate under test in the lab designs.

## Interface
- `WIDTH`, default 2: number of NOR inputs swept; legal range 1..16.
- `SETTLE`, default 1: cycles waited after driving a vector before sampling; legal range 1..255.

- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `start`  in  1  single-cycle request to begin a sweep; ignored while `busy`.
- `dut_in`  in  1  output of the NOR gate under test.
- `vec_out`  out  WIDTH  pattern driven to the gate inputs.
- `exp_out`  out  1  golden value, equal to ~|vec_out; combinational from `vec_out`.
- `busy`  out  1  high while a sweep is in progress.
- `done`  out  1  high while in DONE.
- `pass`  out  1  valid when `done` is high; set when `err_count` is 0.
- `err_count`  out  WIDTH+1  number of mismatching vectors; saturates at 2^WIDTH.
- `fail_valid`  out  1  sticky flag: at least one mismatch has occurred in this sweep.
- `first_fail_vec`  out  WIDTH  first mismatching pattern; holds its value once captured.

## Operation
- Reset, and reset asserted at any point mid-sweep, forces the following immediately without waiting for a clock edge:
  - state IDLE
  - `vec_out`, `err_count` and `first_fail_vec` = 0
  - `busy`, `done`, `pass` and `fail_valid` = 0
- The state machine has four states: IDLE, WAIT, CHECK, DONE.
  - IDLE: `start`=1 → WAIT. On that transition, `vec_out`←0, settle counter←SETTLE, and `err_count`, `fail_valid` and `first_fail_vec` are cleared.
  - WAIT: the settle counter decrements each cycle. When it reaches 1, the next state is CHECK. WAIT therefore lasts exactly SETTLE cycles.
  - CHECK: `dut_in` is sampled and compared with `exp_out`.
    - On a mismatch, `err_count` increments. If `fail_valid` is 0, `first_fail_vec`←`vec_out` and `fail_valid`←1.
    - If `vec_out` is all ones → DONE. Otherwise `vec_out` increments and the state returns to WAIT with the counter reloaded.
  - DONE: `done`=1 and `pass`=(`err_count`==0). `vec_out` holds its last value. `start`=1 → WAIT, which restarts the sweep and clears the results exactly as from IDLE.
- `busy`=1 in WAIT and CHECK only. `start` asserted during WAIT or CHECK has no effect.
- An X or Z value on `dut_in` in CHECK counts as a mismatch.
- The `vec_out` counter is WIDTH bits wide. Termination is detected on the all-ones value, so the counter never wraps.

## Timing
- Each vector occupies SETTLE+1 cycles: SETTLE cycles in WAIT, then 1 cycle in CHECK.
- Let edge 0 be the edge at which `start` is sampled high. `done` rises at edge 2^WIDTH·(SETTLE+1)+1.
  - Example: WIDTH=2, SETTLE=1 gives `done` at edge 9.
- `err_count` and `fail_valid` update on the edge that ends CHECK. They are therefore final when `done` rises.
- `vec_out` is stable for the whole WAIT+CHECK window of each vector.

## Configuration
- `NOR_SWEEP_STOP_ON_FAIL_EN` defined: the first mismatch in CHECK moves the state machine to DONE on the next edge.
  - `vec_out` and `first_fail_vec` both hold the failing pattern.
  - `err_count` = 1 and `pass` = 0.
- `NOR_SWEEP_STOP_ON_FAIL_EN` undefined: the sweep always covers all 2^WIDTH patterns regardless of mismatches.

## Structure
- Package `nor_sweep_pkg` holds:
  - the state encoding constants IDLE=2'd0, WAIT=2'd1, CHECK=2'd2, DONE=2'd3
  - the legal-range limits for WIDTH and SETTLE
- Sub-module `nor_ref`: combinational WIDTH-input golden NOR producing `exp_out`. It is reused by other gate checkers.

## Test plan
- WIDTH=2, SETTLE=1, `dut_in` driven by a correct NOR, `start` pulsed → `done` at edge 9, `pass`=1, `err_count`=0, `vec_out` sequence 0,1,2,3.
- WIDTH=2, `dut_in` tied to 0 → `err_count`=1, `first_fail_vec`=2'b00, `pass`=0, `fail_valid`=1.
- WIDTH=4, SETTLE=3, correct gate → `done` at edge 65, `pass`=1. `start` pulsed again at edge 30 is ignored.
- WIDTH=3, `rst_n` dropped between two clock edges at edge 10 → all outputs 0 immediately, without waiting for an edge. A new `start` produces a full clean sweep.
- `NOR_SWEEP_STOP_ON_FAIL_EN` defined, WIDTH=3, gate stuck at 1 → `done` one edge after the CHECK for `vec_out`=3'b001, `first_fail_vec`=3'b001, `err_count`=1.
- Restart from DONE after a failing sweep, now with a correct gate → `err_count`, `fail_valid` and `first_fail_vec` cleared at restart, and the sweep ends with `pass`=1.

Source files
------------

// File: rtl/nor_sweep_pkg.sv
// Shared state encoding and parameter limits for the NOR sweep checker.
package nor_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int unsigned WIDTH_MIN  = 1;
  localparam int unsigned WIDTH_MAX  = 16;
  localparam int unsigned SETTLE_MIN = 1;
  localparam int unsigned SETTLE_MAX = 255;
  localparam int unsigned SETTLE_W   = 8;

endpackage

// File: rtl/nor_sweep_checker_nor_ref.sv
// Golden WIDTH-input NOR, shared by the gate checkers.
module nor_ref #(
  parameter int unsigned WIDTH = 2
) (
  input  logic [WIDTH-1:0] vec_i,
  output logic             nor_o
);

  assign nor_o = ~|vec_i;

endmodule

// File: rtl/nor_sweep_checker.sv
// Exhaustive sweeper for a WIDTH-input NOR gate with a programmable settle time.
// Define NOR_SWEEP_STOP_ON_FAIL_EN to end the sweep at the first mismatch.
module nor_sweep_checker
  import nor_sweep_pkg::*;
#(
  parameter int unsigned WIDTH  = 2,
  parameter int unsigned SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             dut_in,
  output logic [WIDTH-1:0] vec_out,
  output logic             exp_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH:0]   err_count,
  output logic             fail_valid,
  output logic [WIDTH-1:0] first_fail_vec
);

  localparam int unsigned         ERR_W     = WIDTH + 1;
  localparam logic [ERR_W-1:0]    ERR_MAX   = ERR_W'(1) << WIDTH;
  localparam logic [SETTLE_W-1:0] SETTLE_LD = SETTLE_W'(SETTLE);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX ||
      SETTLE < SETTLE_MIN || SETTLE > SETTLE_MAX) begin : g_bad_param
    $error("nor_sweep_checker: WIDTH or SETTLE out of range");
  end

  state_e              state_q, state_d;
  logic [SETTLE_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]    vec_q, vec_d, ffv_q, ffv_d;
  logic [ERR_W-1:0]    err_q, err_d;
  logic                fv_q, fv_d;
  logic                start_q, start_d;
  logic                busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic                exp_c, mismatch_c, last_vec_c;

  nor_ref #(.WIDTH(WIDTH)) u_nor_ref (
    .vec_i (vec_q),
    .nor_o (exp_c)
  );

  // X/Z on dut_in fails the equality and falls through to a mismatch.
  always_comb begin
    mismatch_c = 1'b1;
    if (dut_in == exp_c) mismatch_c = 1'b0;
  end

  assign last_vec_c = &vec_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start_q) state_d = WAIT;
      WAIT:       if (cnt_q == SETTLE_W'(1)) state_d = CHECK;
      CHECK: begin
`ifdef NOR_SWEEP_STOP_ON_FAIL_EN
        if (mismatch_c || last_vec_c) state_d = DONE;
        else                          state_d = WAIT;
`else
        if (last_vec_c) state_d = DONE;
        else            state_d = WAIT;
`endif
      end
      default:    state_d = IDLE;
    endcase
  end

  // Datapath and registered status, all derived from the next state.
  always_comb begin
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    fv_d    = fv_q;
    ffv_d   = ffv_q;
    start_d = start & ~busy_q;
    case (state_q)
      IDLE, DONE: begin
        if (start_q) begin
          vec_d = '0;
          cnt_d = SETTLE_LD;
          err_d = '0;
          fv_d  = 1'b0;
          ffv_d = '0;
        end
      end
      WAIT: cnt_d = cnt_q - SETTLE_W'(1);
      CHECK: begin
        if (mismatch_c) begin
          if (err_q != ERR_MAX) err_d = err_q + ERR_W'(1);
          if (!fv_q) begin
            ffv_d = vec_q;
            fv_d  = 1'b1;
          end
        end
        if (state_d == WAIT) begin
          vec_d = vec_q + WIDTH'(1);
          cnt_d = SETTLE_LD;
        end
      end
      default: ;
    endcase
    busy_d = (state_d == WAIT) || (state_d == CHECK);
    done_d = (state_d == DONE);
    pass_d = done_d && (err_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_q   <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      fv_q    <= 1'b0;
      ffv_q   <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      fv_q    <= fv_d;
      ffv_q   <= ffv_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign vec_out        = vec_q;
  assign exp_out        = exp_c;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign fail_valid     = fv_q;
  assign first_fail_vec = ffv_q;

endmodule
